r88_mc_ws: RTL and testbench
============================

Name: r88_mc_ws

Overview:
- Parametrised successor to the core's memory controller.
- Holds the external address register and runs single read/write cycles on the external bus.
- Adds programmable wait states, an external ready input for stretching cycles, optional address auto-increment, and parametrised address/data widths.
- Sits between the core's internal data bus and the off-chip address/data bus, driven by the sequencer through a request/done handshake.

Parameters:
AW, 16, address width in bits (>= 9)
DW, 8, data width in bits
WAIT_STATES, 0, minimum extra strobe cycles per access (0..15)
READY_EN, 1, 1 = memReady stretches the access phase; 0 = memReady ignored
AUTO_INC, 0, 1 = address register increments after each completed access

Ports:
sysClock  input  1  system clock; all state changes on rising edge
resetReq  input  1  synchronous active-high reset
extA  output  AW  external address bus = address register
extD  inout  DW  external data bus; driven only while writeMem=1, else high-Z
readMem  output  1  read strobe
writeMem  output  1  write strobe
memReady  input  1  external ready; low stretches the access phase
intDIn  input  DW  internal data bus into controller (write data, address bytes)
intDOut  output  DW  captured read data
regAddr  input  AW  full address from the address register block
mc_write_full  input  1  load address register from regAddr
mc_write_low  input  1  load addr[7:0] from intDIn[7:0]
mc_write_high  input  1  load addr[AW-1:8] from intDIn[AW-9:0]
rdReq  input  1  start read cycle
wrReq  input  1  start write cycle
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when an access completes

Behaviour:
- Reset (sampled on the sysClock edge while resetReq=1):
  - state=IDLE, addr=0, intDOut=0; readMem=writeMem=busy=done=0; extD high-Z.
  - Applies mid-access too: strobes drop at that edge, no done pulse, and any latched write data is discarded.
- Address loads are accepted only in IDLE; in any other state they are ignored.
  - mc_write_full has priority and overrides low/high.
  - Low and high asserted together with full=0: both bytes load in the same cycle.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - rdReq or wrReq at an edge: go to SETUP; latch direction and latch intDIn as write data.
  - Both requests high: read wins, write is dropped.
- SETUP, 1 cycle: extA stable, strobes low, extD still high-Z.
- ACCESS:
  - Strobe (readMem or writeMem) high; extD driven with the write data for writes.
  - Wait counter loads WAIT_STATES on entry and decrements each cycle.
  - Access ends at the first edge where the counter is 0 and (memReady=1 or READY_EN=0).
  - The stretch is unbounded while memReady stays low.
  - Reads: intDOut captures extD at the ending edge.
  - Then go to DONE.
- DONE, 1 cycle: strobes low, extD high-Z, done=1, busy=1.
  - Requests in DONE are ignored; the sequencer must re-request in IDLE.
  - Next state is IDLE.
- Latency: request edge to done high = WAIT_STATES + 2 cycles with memReady held high; strobe width = WAIT_STATES + 1 cycles.
- Auto-increment: with AUTO_INC=1, addr increments by 1 at the DONE→IDLE edge. It wraps from 2^AW-1 to 0 and has no other side effect.
- extA always reflects addr. It never changes between SETUP and DONE.
- readMem and writeMem are never high together.
- intDOut holds its value until the next completed read or reset.

Test Plan:
- Reset then mc_write_full with regAddr=0x1234 in IDLE -> extA=0x1234 next cycle; readMem=writeMem=0; extD high-Z.
- WAIT_STATES=0, memReady=1, rdReq with extD=0xA5 -> readMem high exactly 1 cycle, done 2 cycles after request edge, intDOut=0xA5.
- WAIT_STATES=2, wrReq with intDIn=0x3C, memReady low for first 4 access cycles -> writeMem high 5 cycles; extD=0x3C throughout; done one cycle after writeMem falls.
- AUTO_INC=1, addr=0xFFFF, two back-to-back reads -> first at 0xFFFF, second at 0x0000, then extA=0x0001.
- rdReq and wrReq together; then mc_write_low=0x55 issued during ACCESS -> read cycle only; address unchanged.
- resetReq asserted mid-ACCESS of a write -> writeMem=0 and extD high-Z at the reset edge; no done pulse; addr=0.

Source files
------------

// File: rtl/r88_mc_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | r88_mc_ws : external memory controller, programmable wait states/ready     |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module r88_mc_ws #(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 0,
  parameter int READY_EN    = 1,
  parameter int AUTO_INC    = 0
) (
  input  logic          sysClock,
  input  logic          resetReq,
  output logic [AW-1:0] extA,
  inout  wire  [DW-1:0] extD,
  output logic          readMem,
  output logic          writeMem,
  input  logic          memReady,
  input  logic [DW-1:0] intDIn,
  output logic [DW-1:0] intDOut,
  input  logic [AW-1:0] regAddr,
  input  logic          mc_write_full,
  input  logic          mc_write_low,
  input  logic          mc_write_high,
  input  logic          rdReq,
  input  logic          wrReq,
  output logic          busy,
  output logic          done
);

  localparam logic [3:0] c_WAIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_dout;
  logic [DW-1:0]   r_wdata;
  logic            r_is_wr;
  logic [3:0]      r_wcnt;
  logic            w_acc_end;
  logic [7:0]      w_lo;
  logic [AW-9:0]   w_hi;
  logic [AW-1:0]   w_addr_ld;

  // Byte sources for the split address loads, zero-extended if the data bus is narrow
  if (DW >= 8) begin : g_lo_direct
    assign w_lo = intDIn[7:0];
  end else begin : g_lo_ext
    assign w_lo = {{(8-DW){1'b0}}, intDIn};
  end

  if (AW - 8 <= DW) begin : g_hi_direct
    assign w_hi = intDIn[AW-9:0];
  end else begin : g_hi_ext
    assign w_hi = {{(AW-8-DW){1'b0}}, intDIn};
  end

  always_comb begin
    w_addr_ld = r_addr;
    if (mc_write_full) begin
      w_addr_ld = regAddr;
    end else begin
      if (mc_write_low)  w_addr_ld[7:0]    = w_lo;
      if (mc_write_high) w_addr_ld[AW-1:8] = w_hi;
    end
  end

  assign w_acc_end = (r_wcnt == 4'd0) && (memReady || (READY_EN == 0));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (rdReq || wrReq) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_acc_end) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sysClock) begin
    if (resetReq) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_dout  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_addr <= w_addr_ld;
          // Read wins when both requests arrive together
          if (rdReq || wrReq) begin
            r_is_wr <= ~rdReq;
            r_wdata <= intDIn;
          end
        end
        S_SETUP: r_wcnt <= c_WAIT;
        S_ACCESS: begin
          if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
          if (w_acc_end && !r_is_wr) r_dout <= extD;
        end
        S_DONE: if (AUTO_INC != 0) r_addr <= r_addr + AW'(1);
        default: ;
      endcase
    end
  end

  assign extA     = r_addr;
  assign intDOut  = r_dout;
  assign readMem  = (r_state == S_ACCESS) && !r_is_wr;
  assign writeMem = (r_state == S_ACCESS) &&  r_is_wr;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign extD     = writeMem ? r_wdata : {DW{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_r88_mc_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_r88_mc_ws : scoreboard bench for r88_mc_ws (WAIT_STATES=2, AUTO_INC=1)  |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_r88_mc_ws;

  localparam int WS = 2;

  logic        sysClock = 1'b0;
  logic        resetReq = 1'b1;
  logic        memReady = 1'b1;
  logic        rdReq = 1'b0, wrReq = 1'b0;
  logic        mc_write_full = 1'b0, mc_write_low = 1'b0, mc_write_high = 1'b0;
  logic [7:0]  intDIn = 8'h00;
  logic [7:0]  tb_d = 8'h00;
  logic [15:0] regAddr = 16'h0000;
  wire  [15:0] extA;
  wire  [7:0]  extD;
  wire  [7:0]  intDOut;
  wire         readMem, writeMem, busy, done;

  // The bench acts as the memory: it owns the bus whenever the controller is not writing
  assign extD = writeMem ? 8'bz : tb_d;

  r88_mc_ws #(.AW(16), .DW(8), .WAIT_STATES(WS), .READY_EN(1), .AUTO_INC(1)) dut (
    .sysClock(sysClock), .resetReq(resetReq), .extA(extA), .extD(extD),
    .readMem(readMem), .writeMem(writeMem), .memReady(memReady),
    .intDIn(intDIn), .intDOut(intDOut), .regAddr(regAddr),
    .mc_write_full(mc_write_full), .mc_write_low(mc_write_low),
    .mc_write_high(mc_write_high), .rdReq(rdReq), .wrReq(wrReq),
    .busy(busy), .done(done)
  );

  always #5 sysClock = ~sysClock;

  typedef struct {
    logic [15:0] addr;
    bit          wr;
    logic [7:0]  wdata;
    logic [7:0]  dout;
    int          width;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0]  m_last = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // kind: 0 read, 1 write, 2 both requests; ld: 0 none, 1 full, 2 low, 3 high, 4 low+high, 5 full+low
  task automatic do_txn(input int kind, input int nlow, input int ld, input logic [15:0] la);
    exp_t e;
    logic [7:0] wd, rd;
    int i;
    bit seen;
    if (ld != 0) begin
      regAddr = 16'($urandom);
      intDIn  = la[7:0];
      case (ld)
        1: begin mc_write_full = 1'b1; regAddr = la; m_addr = la; end
        2: begin mc_write_low = 1'b1; m_addr[7:0] = la[7:0]; end
        3: begin mc_write_high = 1'b1; m_addr[15:8] = la[7:0]; end
        4: begin mc_write_low = 1'b1; mc_write_high = 1'b1; m_addr = {la[7:0], la[7:0]}; end
        default: begin
          mc_write_full = 1'b1; mc_write_low = 1'b1; regAddr = la; intDIn = ~la[7:0]; m_addr = la;
        end
      endcase
      @(negedge sysClock);
      mc_write_full = 1'b0; mc_write_low = 1'b0; mc_write_high = 1'b0;
      check("addr_load", extA, m_addr);
    end
    wd = 8'($urandom);
    rd = 8'($urandom);
    rdReq  = (kind != 1);
    wrReq  = (kind != 0);
    intDIn = wd;
    tb_d   = rd;
    e.addr  = m_addr;
    e.wr    = (kind == 1);
    e.wdata = wd;
    if (!e.wr) m_last = rd;
    e.dout  = m_last;
    e.width = ((nlow > WS) ? nlow : WS) + 1;
    q.push_back(e);
    @(negedge sysClock);
    rdReq = 1'b0; wrReq = 1'b0;
    intDIn = 8'($urandom);
    i = 0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      mc_write_low = 1'b0;
      if (readMem || writeMem) begin
        i++;
        memReady = (i > nlow);
        if (i == 1) begin mc_write_low = 1'b1; intDIn = 8'h55; end
      end
      if (done) begin seen = 1'b1; rdReq = 1'b1; end
      @(negedge sysClock);
    end
    mc_write_low = 1'b0; rdReq = 1'b0; memReady = 1'b1;
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL txn_timeout: got no done within 60 cycles, expected done");
    end else begin
      m_addr = m_addr + 16'd1;
    end
  endtask

  // Monitor: tracks each access and scores it against the queue head when done appears
  initial begin
    int bc, sc;
    logic [15:0] a0, sa;
    logic sw;
    logic [7:0] swd;
    bit wvar;
    exp_t e;
    bc = 0; sc = 0; wvar = 1'b0; a0 = '0; sa = '0; sw = 1'b0; swd = '0;
    forever begin
      @(negedge sysClock);
      #1;
      if (mon_en) begin
        check("strobe_excl", {31'd0, readMem & writeMem}, 0);
        if (!writeMem) check("extD_released", extD, tb_d);
        if (busy) begin
          bc++;
          if (bc == 1) a0 = extA;
          else check("extA_stable", extA, a0);
          if (readMem || writeMem) begin
            sc++;
            if (sc == 1) begin sa = extA; sw = writeMem; swd = extD; end
            else if (writeMem && extD !== swd) wvar = 1'b1;
          end
          if (done) begin
            if (q.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL unexpected_done: got done=1 expected no pending access");
            end else begin
              e = q.pop_front();
              check("acc_addr", sa, e.addr);
              check("acc_dir", {31'd0, sw}, {31'd0, e.wr});
              check("strobe_width", sc, e.width);
              check("done_latency", bc, e.width + 2);
              check("intDOut", intDOut, e.dout);
              if (e.wr) begin
                check("write_data", swd, e.wdata);
                check("write_data_steady", {31'd0, wvar}, 0);
              end
            end
          end
        end else begin
          bc = 0; sc = 0; wvar = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge sysClock);
    check("rst_extA", extA, 0);
    check("rst_intDOut", intDOut, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_strobes", {30'd0, readMem, writeMem}, 0);
    resetReq = 1'b0;
    mon_en = 1'b1;
    @(negedge sysClock);

    do_txn(0, 0, 1, 16'h1234);
    do_txn(1, 4, 0, 16'h0000);
    do_txn(2, 0, 2, 16'h00AB);
    do_txn(0, 0, 1, 16'hFFFF);
    do_txn(0, 0, 0, 16'h0000);
    check("wrap_extA", extA, 16'h0001);

    for (int n = 0; n < 30; n++)
      do_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 5)), 16'($urandom));

    // Reset in the middle of a stretched write
    mc_write_full = 1'b1; regAddr = 16'h0F0F;
    @(negedge sysClock);
    mc_write_full = 1'b0; wrReq = 1'b1; intDIn = 8'h3C;
    @(negedge sysClock);
    wrReq = 1'b0; memReady = 1'b0;
    k = 0;
    while (!writeMem && k < 10) begin @(negedge sysClock); k++; end
    check("rst_wr_started", {31'd0, writeMem}, 1);
    @(negedge sysClock);
    resetReq = 1'b1;
    @(negedge sysClock);
    check("midrst_writeMem", {31'd0, writeMem}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_extA", extA, 0);
    check("midrst_intDOut", intDOut, 0);
    resetReq = 1'b0; memReady = 1'b1;
    m_addr = 16'h0000; m_last = 8'h00;
    repeat (4) begin
      @(negedge sysClock);
      check("midrst_no_done", {31'd0, done}, 0);
    end

    do_txn(0, 1, 0, 16'h0000);
    do_txn(1, 0, 0, 16'h0000);
    repeat (3) @(negedge sysClock);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
